keccak_state_loader: RTL and testbench
======================================

// Module: keccak_state_loader
// PURPOSE
//  Parametrised front end for the permutation core. Unpacks the push/first/stop lane
//  stream into NBANK ping-pong 5x5 lane banks (m55-style write port) and hands full
//  states to the core. Lane width is generic, covering Keccak-f[200..1600]. Adds
//  multi-bank buffering, backpressure and framing-error detection.
// PARAMETERS
//  LANE_W   64  lane width in bits; legal values 8, 16, 32, 64
//  NBANK    2   number of state banks, 1..4; BW = (NBANK>1) ? $clog2(NBANK) : 1
// PORTS
//  clk       in   1       clock, all logic on posedge
//  reset     in   1       synchronous, active-high
//  pushin    in   1       lane valid from NoC interface
//  firstin   in   1       marks lane 0 (x=0,y=0) of a new state
//  din       in   LANE_W  lane data
//  stopin    out  1       backpressure to upstream; registered
//  wx,wy     out  3       write lane address, x 0..4, y 0..4
//  wr        out  1       write strobe
//  wd        out  LANE_W  write data
//  wbank     out  BW      bank selected by wr
//  st_valid  out  1       at least one FULL bank is available
//  st_bank   out  BW      oldest FULL bank, valid when st_valid=1
//  st_take   in   1       core claims st_bank (FULL->BUSY); ignored if !st_valid
//  st_rel    in   1       core frees bank rel_bank (BUSY->EMPTY)
//  rel_bank  in   BW      bank being released
//  err       out  1       one-cycle pulse on framing or overflow error
// BEHAVIOUR
//  Reset:
//   - all banks EMPTY; fill pointer 0; lane index 0.
//   - wr, stopin, st_valid and err are 0; wx, wy, wd, wbank and st_bank are 0.
//  Lane order:
//   - idx = x + 5*y, x fastest, 25 lanes per state. idx wraps 24 -> 0.
//  Write latency:
//   - Accepted push at cycle t drives wr/wx/wy/wd/wbank at t+1.
//  Bank states (per bank, 2-bit): EMPTY -> FILL -> FULL -> BUSY -> EMPTY.
//   - EMPTY->FILL: an accepted firstin push targets this bank (fill pointer).
//   - FILL->FULL: lane 24 is accepted. The fill pointer advances round-robin to the
//     next bank.
//   - FULL->BUSY: st_take while this bank is st_bank.
//   - BUSY->EMPTY: st_rel with rel_bank equal to this bank. st_rel on a non-BUSY bank
//     is ignored and pulses err.
//  Handoff order:
//   - st_bank is the oldest FULL bank, FIFO order by completion.
//   - st_valid rises at t+2 after lane 24 is pushed at t.
//  Backpressure:
//   - stopin(t+1) = 1 when the bank at the fill pointer is not EMPTY/FILL at t.
//   - Equivalently, all banks are FULL or BUSY, or the next bank would be.
//   - Upstream may push at most 1 cycle after stopin rises; that push is still
//     accepted (1-deep skid).
//   - Any further push while stopin=1 is dropped and pulses err.
//  Framing:
//   - firstin while idx!=0: the partial state is discarded. This lane is written as
//     lane 0 of the same bank and err pulses.
//   - Push with idx==0 and firstin=0: the lane is dropped, err pulses, idx stays 0.
//  Simultaneous events:
//   - st_rel and lane-24 completion in the same cycle both take effect; stopin
//     deasserts next cycle if a bank freed.
//   - st_take and st_rel on the same bank in one cycle: take is applied first, then
//     rel is illegal (bank was FULL), so err pulses.
//   - NBANK=1 degenerates to a single buffer; stopin stays high from FULL until release.
//  Reset mid-operation:
//   - Partial fills and FULL/BUSY banks are abandoned; all state is reinitialised as
//     at power-up.
// STRUCTURE
//  - keccak_pkg:
//    - bank_st_e {EMPTY, FILL, FULL, BUSY}
//    - LANES=25
//    - function lane_xy(idx) -> {x,y}
//    - legal LANE_W check
//  - Sub-module keccak_lane_ctr: x/y/idx counter with clear, advance and wrap-at-24
//    flag.
//  - Top level holds the bank state array, fill pointer, completion-order FIFO
//    (depth NBANK), skid control and err.
// TESTING
//  1. Reset, then 25 pushes of din=idx with firstin on lane 0 ->
//     - wr at lanes (0,0)..(4,4), wbank=0, wd=idx;
//     - st_valid=1 with st_bank=0 two cycles after the last push.
//  2. NBANK=2, three back-to-back states with no st_take ->
//     - banks 0 and 1 FULL;
//     - stopin rises; one skid push accepted; the next push drops and pulses err.
//  3. st_take then st_rel(rel_bank=0) while stopin=1 ->
//     - bank 0 becomes EMPTY; stopin drops 1 cycle later;
//     - the third state fills bank 0; st_bank order is 1 then 0.
//  4. firstin at idx=7 ->
//     - one err pulse; wx=0,wy=0 written in the same bank;
//     - 24 more lanes complete the state normally.
//  5. Push without firstin after reset -> err pulse, no wr, idx remains 0.
//  6. LANE_W=8, NBANK=4:
//     - four states fill banks 0..3 in order;
//     - reset asserted at lane 12 of the fifth state -> all outputs 0 next cycle;
//       st_valid=0.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared types and helpers for the Keccak state loader: bank states, lane count,
// lane index to (x,y) mapping and the legal lane-width set.
package keccak_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2,
      BUSY  = 2'd3
   } bank_st_e;

   localparam int         LANES    = 25;
   localparam logic [4:0] LAST_IDX = 5'(LANES - 1);

   // idx = x + 5*y, returned as {x, y}
   function automatic logic [5:0] lane_xy(input logic [4:0] idx);
      logic [4:0] rem;
      logic [2:0] y;
      rem = idx;
      y   = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (rem >= 5'd5) begin
            rem = rem - 5'd5;
            y   = y + 3'd1;
         end else begin
            rem = rem;
         end
      end
      return {rem[2:0], y};
   endfunction

   function automatic bit lane_w_ok(input int w);
      return (w == 8) || (w == 16) || (w == 32) || (w == 64);
   endfunction

endpackage

// File: rtl/keccak_lane_ctr.sv
// Lane position counter: idx with registered x/y, clear, advance and wrap at lane 24.
// clr and adv together restart the count at lane 1 (lane 0 is being written now).
module keccak_lane_ctr
   import keccak_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       adv,
   output logic [4:0] idx,
   output logic [2:0] x,
   output logic [2:0] y,
   output logic       last
);

   logic [4:0] idx_r;
   logic [4:0] base_s;
   logic [4:0] idx_n;
   logic [2:0] x_r;
   logic [2:0] y_r;

   // next lane index
   always_comb begin
      base_s = clr ? 5'd0 : idx_r;
      idx_n  = base_s;
      if (adv) begin
         if (base_s == LAST_IDX) begin
            idx_n = 5'd0;
         end else begin
            idx_n = base_s + 5'd1;
         end
      end else begin
         idx_n = base_s;
      end
   end

   // counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_r <= 5'd0;
         x_r   <= 3'd0;
         y_r   <= 3'd0;
      end else begin
         idx_r      <= idx_n;
         {x_r, y_r} <= lane_xy(idx_n);
      end
   end

   assign idx  = idx_r;
   assign x    = x_r;
   assign y    = y_r;
   assign last = (idx_r == LAST_IDX);

endmodule

// File: rtl/keccak_state_loader.sv
// Unpacks a lane stream into NBANK 5x5 lane banks and hands completed states to the
// permutation core in completion order, with a 1-deep skid, backpressure and error pulse.
module keccak_state_loader
   import keccak_pkg::*;
#(
   parameter int  LANE_W = 64,
   parameter int  NBANK  = 2,
   localparam int BW     = (NBANK > 1) ? $clog2(NBANK) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pushin,
   input  logic              firstin,
   input  logic [LANE_W-1:0] din,
   output logic              stopin,
   output logic [2:0]        wx,
   output logic [2:0]        wy,
   output logic              wr,
   output logic [LANE_W-1:0] wd,
   output logic [BW-1:0]     wbank,
   output logic              st_valid,
   output logic [BW-1:0]     st_bank,
   input  logic              st_take,
   input  logic              st_rel,
   input  logic [BW-1:0]     rel_bank,
   output logic              err
);

   localparam int            QD        = 1 << BW;
   localparam int            CW        = BW + 1;
   localparam logic [BW-1:0] LAST_BANK = BW'(NBANK - 1);

   if (!lane_w_ok(LANE_W) || (NBANK < 1) || (NBANK > 4)) begin : g_bad_param
      $error("keccak_state_loader: illegal LANE_W or NBANK");
   end

   bank_st_e          bank_r [QD];
   bank_st_e          bank_n [QD];
   logic [BW-1:0]     fptr_r, fptr_n;
   logic              skid_v_r, skid_v_n, skid_first_r;
   logic [LANE_W-1:0] skid_d_r;
   logic              stop_prev_r;
   logic              done_r, done_n;
   logic [BW-1:0]     done_bank_r;
   logic [BW-1:0]     q_r [QD];
   logic [BW-1:0]     q_n [QD];
   logic [CW-1:0]     cnt_r, cnt_n;

   logic              push_acc_s, lane_v_s, lane_first_s, writable_s, load_skid_s, pop_s;
   logic [LANE_W-1:0] lane_d_s;
   logic              ctr_clr_s, ctr_adv_s, clast_s;
   logic [4:0]        idx_s;
   logic [2:0]        cx_s, cy_s;
   logic              wr_n, err_n, stopin_n, st_valid_n;
   logic [2:0]        wx_n, wy_n;
   logic [LANE_W-1:0] wd_n;
   logic [BW-1:0]     wbank_n, st_bank_n;

   keccak_lane_ctr u_ctr (
      .clk   (clk),
      .reset (reset),
      .clr   (ctr_clr_s),
      .adv   (ctr_adv_s),
      .idx   (idx_s),
      .x     (cx_s),
      .y     (cy_s),
      .last  (clast_s)
   );

   // lane acceptance, framing, bank transitions and backpressure
   always_comb begin
      // a push is accepted while stopin is low, or in the first cycle it is high
      push_acc_s   = pushin && !skid_v_r && (!stopin || !stop_prev_r);
      lane_v_s     = skid_v_r || push_acc_s;
      lane_first_s = skid_v_r ? skid_first_r : firstin;
      lane_d_s     = skid_v_r ? skid_d_r : din;
      writable_s   = (bank_r[fptr_r] == EMPTY) || (bank_r[fptr_r] == FILL);

      bank_n      = bank_r;
      fptr_n      = fptr_r;
      skid_v_n    = skid_v_r;
      load_skid_s = 1'b0;
      done_n      = 1'b0;
      ctr_clr_s   = 1'b0;
      ctr_adv_s   = 1'b0;
      wr_n        = 1'b0;
      wx_n        = wx;
      wy_n        = wy;
      wd_n        = wd;
      wbank_n     = wbank;
      err_n       = pushin && !push_acc_s;

      if (lane_v_s && !writable_s) begin
         load_skid_s = !skid_v_r;
         skid_v_n    = 1'b1;
      end else if (lane_v_s) begin
         skid_v_n = 1'b0;
         if (lane_first_s) begin
            wr_n              = 1'b1;
            wx_n              = 3'd0;
            wy_n              = 3'd0;
            wd_n              = lane_d_s;
            wbank_n           = fptr_r;
            ctr_clr_s         = 1'b1;
            ctr_adv_s         = 1'b1;
            bank_n[fptr_r]    = FILL;
            err_n             = err_n || (idx_s != 5'd0);
         end else if (idx_s == 5'd0) begin
            err_n = 1'b1;
         end else begin
            wr_n      = 1'b1;
            wx_n      = cx_s;
            wy_n      = cy_s;
            wd_n      = lane_d_s;
            wbank_n   = fptr_r;
            ctr_adv_s = 1'b1;
            if (clast_s) begin
               bank_n[fptr_r] = FULL;
               fptr_n         = (fptr_r == LAST_BANK) ? '0 : fptr_r + BW'(1);
               done_n         = 1'b1;
            end else begin
               done_n = 1'b0;
            end
         end
      end else begin
         skid_v_n = skid_v_r;
      end

      if (st_take && st_valid) begin
         bank_n[st_bank] = BUSY;
      end else begin
         bank_n[st_bank] = bank_n[st_bank];
      end

      // rel is judged on the pre-take state, so take+rel on one bank is an error
      if (st_rel) begin
         if (bank_r[rel_bank] == BUSY) begin
            bank_n[rel_bank] = EMPTY;
         end else begin
            err_n = 1'b1;
         end
      end else begin
         err_n = err_n;
      end

      stopin_n = !((bank_n[fptr_n] == EMPTY) || (bank_n[fptr_n] == FILL)) || skid_v_n;
   end

   // completion-order queue of FULL banks
   always_comb begin
      pop_s = st_take && st_valid;
      q_n   = q_r;
      cnt_n = cnt_r;
      if (pop_s) begin
         for (int i = 0; i < QD - 1; i++) begin
            q_n[i] = q_r[i + 1];
         end
         cnt_n = cnt_r - CW'(1);
      end else begin
         cnt_n = cnt_r;
      end
      if (done_r) begin
         q_n[cnt_n[BW-1:0]] = done_bank_r;
         cnt_n              = cnt_n + CW'(1);
      end else begin
         cnt_n = cnt_n;
      end
      st_valid_n = (cnt_n != '0);
      st_bank_n  = q_n[0];
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < QD; i++) begin
            bank_r[i] <= EMPTY;
            q_r[i]    <= '0;
         end
         fptr_r       <= '0;
         skid_v_r     <= 1'b0;
         skid_first_r <= 1'b0;
         skid_d_r     <= '0;
         stop_prev_r  <= 1'b0;
         done_r       <= 1'b0;
         done_bank_r  <= '0;
         cnt_r        <= '0;
         stopin       <= 1'b0;
         wr           <= 1'b0;
         wx           <= 3'd0;
         wy           <= 3'd0;
         wd           <= '0;
         wbank        <= '0;
         st_valid     <= 1'b0;
         st_bank      <= '0;
         err          <= 1'b0;
      end else begin
         for (int i = 0; i < QD; i++) begin
            bank_r[i] <= bank_n[i];
            q_r[i]    <= q_n[i];
         end
         fptr_r      <= fptr_n;
         skid_v_r    <= skid_v_n;
         if (load_skid_s) begin
            skid_first_r <= firstin;
            skid_d_r     <= din;
         end else begin
            skid_first_r <= skid_first_r;
            skid_d_r     <= skid_d_r;
         end
         stop_prev_r <= stopin;
         done_r      <= done_n;
         done_bank_r <= fptr_r;
         cnt_r       <= cnt_n;
         stopin      <= stopin_n;
         wr          <= wr_n;
         wx          <= wx_n;
         wy          <= wy_n;
         wd          <= wd_n;
         wbank       <= wbank_n;
         st_valid    <= st_valid_n;
         st_bank     <= st_bank_n;
         err         <= err_n;
      end
   end

endmodule

// File: tb/tb_keccak_state_loader.sv
// Directed bench for keccak_state_loader: a 64-bit/2-bank instance and an 8-bit/4-bank instance.
module tb_keccak_state_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        reset, pushin, firstin, st_take, st_rel, rel_bank;
   logic [63:0] din;
   logic        stopin, wr, st_valid, err, wbank, st_bank;
   logic [2:0]  wx, wy;
   logic [63:0] wd;

   logic        b_reset, b_pushin, b_firstin, b_st_take, b_st_rel;
   logic [1:0]  b_rel_bank;
   logic [7:0]  b_din;
   logic        b_stopin, b_wr, b_st_valid, b_err;
   logic [1:0]  b_wbank, b_st_bank;
   logic [2:0]  b_wx, b_wy;
   logic [7:0]  b_wd;

   keccak_state_loader #(.LANE_W(64), .NBANK(2)) dut_a (
      .clk(clk), .reset(reset), .pushin(pushin), .firstin(firstin), .din(din),
      .stopin(stopin), .wx(wx), .wy(wy), .wr(wr), .wd(wd), .wbank(wbank),
      .st_valid(st_valid), .st_bank(st_bank), .st_take(st_take), .st_rel(st_rel),
      .rel_bank(rel_bank), .err(err)
   );

   keccak_state_loader #(.LANE_W(8), .NBANK(4)) dut_b (
      .clk(clk), .reset(b_reset), .pushin(b_pushin), .firstin(b_firstin), .din(b_din),
      .stopin(b_stopin), .wx(b_wx), .wy(b_wy), .wr(b_wr), .wd(b_wd), .wbank(b_wbank),
      .st_valid(b_st_valid), .st_bank(b_st_bank), .st_take(b_st_take), .st_rel(b_st_rel),
      .rel_bank(b_rel_bank), .err(b_err)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic f, input logic [63:0] d);
      pushin  = 1'b1;
      firstin = f;
      din     = d;
      cyc();
      pushin  = 1'b0;
      firstin = 1'b0;
   endtask

   task automatic bpush(input logic f, input logic [7:0] d);
      b_pushin  = 1'b1;
      b_firstin = f;
      b_din     = d;
      cyc();
      b_pushin  = 1'b0;
      b_firstin = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pushin = 1'b0; firstin = 1'b0; din = 64'd0;
      st_take = 1'b0; st_rel = 1'b0; rel_bank = 1'b0;
      b_reset = 1'b1; b_pushin = 1'b0; b_firstin = 1'b0; b_din = 8'd0;
      b_st_take = 1'b0; b_st_rel = 1'b0; b_rel_bank = 2'd0;
      cyc();
      cyc();

      // reset values
      chk("rst_wr", wr, 64'd0);
      chk("rst_stopin", stopin, 64'd0);
      chk("rst_st_valid", st_valid, 64'd0);
      chk("rst_err", err, 64'd0);
      chk("rst_wx", wx, 64'd0);
      chk("rst_wy", wy, 64'd0);
      chk("rst_wd", wd, 64'd0);
      chk("rst_wbank", wbank, 64'd0);
      chk("rst_st_bank", st_bank, 64'd0);
      reset = 1'b0;

      // 1: one full state into bank 0
      for (int i = 0; i < 25; i++) begin
         push(i == 0, 64'(i));
         chk("t1_wr", wr, 64'd1);
         chk("t1_wx", wx, 64'(i % 5));
         chk("t1_wy", wy, 64'(i / 5));
         chk("t1_wd", wd, 64'(i));
         chk("t1_wbank", wbank, 64'd0);
      end
      chk("t1_st_valid_early", st_valid, 64'd0);
      cyc();
      chk("t1_st_valid", st_valid, 64'd1);
      chk("t1_st_bank", st_bank, 64'd0);
      chk("t1_wr_idle", wr, 64'd0);

      // 2: two states fill both banks, third state hits backpressure
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 25; i++) begin
            push(i == 0, 64'(100 * s + i));
         end
         chk("t2_wbank", wbank, 64'(s));
      end
      chk("t2_stopin_rise", stopin, 64'd1);
      push(1'b1, 64'hC0);
      chk("t2_skid_stopin", stopin, 64'd1);
      chk("t2_skid_no_wr", wr, 64'd0);
      chk("t2_skid_no_err", err, 64'd0);
      push(1'b0, 64'hC1);
      chk("t2_drop_err", err, 64'd1);
      chk("t2_drop_no_wr", wr, 64'd0);
      cyc();
      chk("t2_err_clear", err, 64'd0);
      chk("t2_stopin_hold", stopin, 64'd1);
      chk("t2_st_valid", st_valid, 64'd1);
      chk("t2_st_bank", st_bank, 64'd0);

      // 3: take and release bank 0, third state lands in bank 0
      st_take = 1'b1;
      cyc();
      st_take = 1'b0;
      chk("t3_st_bank_next", st_bank, 64'd1);
      chk("t3_stopin_busy", stopin, 64'd1);
      st_rel = 1'b1; rel_bank = 1'b0;
      cyc();
      st_rel = 1'b0;
      chk("t3_rel_ok", err, 64'd0);
      cyc();
      chk("t3_stopin_drop", stopin, 64'd0);
      chk("t3_skid_wr", wr, 64'd1);
      chk("t3_skid_wx", wx, 64'd0);
      chk("t3_skid_wy", wy, 64'd0);
      chk("t3_skid_wbank", wbank, 64'd0);
      chk("t3_skid_wd", wd, 64'hC0);
      for (int i = 1; i < 25; i++) begin
         push(1'b0, 64'(200 + i));
      end
      chk("t3_last_wbank", wbank, 64'd0);
      chk("t3_last_wx", wx, 64'd4);
      chk("t3_last_wy", wy, 64'd4);
      chk("t3_last_wd", wd, 64'd224);
      cyc();
      chk("t3_order_first", st_bank, 64'd1);
      st_take = 1'b1;
      cyc();
      st_take = 1'b0;
      chk("t3_order_second", st_bank, 64'd0);
      chk("t3_order_valid", st_valid, 64'd1);
      st_take = 1'b1; st_rel = 1'b1; rel_bank = 1'b0;
      cyc();
      st_take = 1'b0; st_rel = 1'b0;
      chk("t3_take_rel_err", err, 64'd1);
      chk("t3_none_full", st_valid, 64'd0);
      st_rel = 1'b1; rel_bank = 1'b0;
      cyc();
      chk("t3_rel0_ok", err, 64'd0);
      rel_bank = 1'b1;
      cyc();
      st_rel = 1'b0;
      chk("t3_rel1_ok", err, 64'd0);
      chk("t3_stopin_free", stopin, 64'd0);
      st_rel = 1'b1; rel_bank = 1'b1;
      cyc();
      st_rel = 1'b0;
      chk("t3_rel_empty_err", err, 64'd1);

      // 4: firstin in mid-state restarts the same bank (bank 1)
      for (int i = 0; i < 7; i++) begin
         push(i == 0, 64'(300 + i));
      end
      chk("t4_lane6_wx", wx, 64'd1);
      chk("t4_lane6_wy", wy, 64'd1);
      push(1'b1, 64'hAA);
      chk("t4_frame_err", err, 64'd1);
      chk("t4_frame_wr", wr, 64'd1);
      chk("t4_frame_wx", wx, 64'd0);
      chk("t4_frame_wy", wy, 64'd0);
      chk("t4_frame_wbank", wbank, 64'd1);
      chk("t4_frame_wd", wd, 64'hAA);
      for (int i = 1; i < 25; i++) begin
         push(1'b0, 64'(400 + i));
         if (i == 1) begin
            chk("t4_lane1_wx", wx, 64'd1);
            chk("t4_lane1_err", err, 64'd0);
         end
      end
      chk("t4_last_wx", wx, 64'd4);
      chk("t4_last_wy", wy, 64'd4);
      chk("t4_last_wbank", wbank, 64'd1);
      chk("t4_last_err", err, 64'd0);
      cyc();
      chk("t4_st_valid", st_valid, 64'd1);
      chk("t4_st_bank", st_bank, 64'd1);

      // 5: push without firstin right after reset
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      push(1'b0, 64'h55);
      chk("t5_err", err, 64'd1);
      chk("t5_no_wr", wr, 64'd0);
      push(1'b1, 64'h66);
      chk("t5_first_err", err, 64'd0);
      chk("t5_first_wr", wr, 64'd1);
      chk("t5_first_wx", wx, 64'd0);
      push(1'b0, 64'h77);
      chk("t5_next_wx", wx, 64'd1);
      chk("t5_next_wd", wd, 64'h77);

      // 6: 8-bit lanes, four banks, reset in the middle of the fifth state
      b_reset = 1'b1;
      cyc();
      b_reset = 1'b0;
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < 25; i++) begin
            bpush(i == 0, 8'(s * 25 + i));
         end
         chk("t6_wbank", b_wbank, 64'(s));
         chk("t6_wd", b_wd, 64'(s * 25 + 24));
      end
      chk("t6_stopin_full", b_stopin, 64'd1);
      cyc();
      chk("t6_st_bank0", b_st_bank, 64'd0);
      b_st_take = 1'b1;
      cyc();
      b_st_take = 1'b0;
      chk("t6_st_bank1", b_st_bank, 64'd1);
      b_st_rel = 1'b1; b_rel_bank = 2'd0;
      cyc();
      b_st_rel = 1'b0;
      chk("t6_stopin_free", b_stopin, 64'd0);
      for (int i = 0; i < 12; i++) begin
         bpush(i == 0, 8'(8'h80 + i));
      end
      chk("t6_lane11_wbank", b_wbank, 64'd0);
      chk("t6_lane11_wx", b_wx, 64'd1);
      chk("t6_lane11_wy", b_wy, 64'd2);
      b_reset = 1'b1;
      bpush(1'b0, 8'h8C);
      b_reset = 1'b0;
      chk("t6_rst_wr", b_wr, 64'd0);
      chk("t6_rst_wx", b_wx, 64'd0);
      chk("t6_rst_wy", b_wy, 64'd0);
      chk("t6_rst_wd", b_wd, 64'd0);
      chk("t6_rst_wbank", b_wbank, 64'd0);
      chk("t6_rst_stopin", b_stopin, 64'd0);
      chk("t6_rst_st_valid", b_st_valid, 64'd0);
      chk("t6_rst_st_bank", b_st_bank, 64'd0);
      chk("t6_rst_err", b_err, 64'd0);
      bpush(1'b0, 8'h11);
      chk("t6_post_rst_err", b_err, 64'd1);
      bpush(1'b1, 8'h22);
      chk("t6_post_rst_wbank", b_wbank, 64'd0);
      chk("t6_post_rst_wd", b_wd, 64'h22);
      chk("t6_post_rst_ok", b_err, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
